// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy node mux and its arbiter.
package hier_node_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Widest node supported by a single hier_node_mux instance.
  localparam int MAX_CH = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hier_node_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NUM_CH. grant is one-hot and gated by en; grant_idx
// always reports the candidate winner (meaningless when no request is set).
module rr_arbiter
  import hier_node_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_idx
);

  logic            high_hit;
  logic            low_hit;
  logic [ID_W-1:0] high_idx;
  logic [ID_W-1:0] low_idx;
  logic            found;

  // Lowest requester at/after ptr wins; otherwise lowest requester below ptr.
  always_comb begin
    high_hit = 1'b0;
    low_hit  = 1'b0;
    high_idx = '0;
    low_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        high_hit = 1'b1;
        high_idx = ID_W'(i);
      end
      if (req[i] && (i < int'(ptr))) begin
        low_hit = 1'b1;
        low_idx = ID_W'(i);
      end
    end
    found     = high_hit || low_hit;
    grant_idx = high_hit ? high_idx : low_idx;
    grant     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (found && en && (grant_idx == ID_W'(i))) grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/hier_node_mux.sv
// Hierarchy node: merges NUM_CH child valid/ready streams into one registered
// upstream stream tagged with the source channel index. Round-robin
// arbitration; one output register slot with full 1 beat/cycle throughput.
// Optional packet lock (keep granting one child until its in_last beat) is
// built when HIER_NODE_PKT_LOCK_EN is defined; otherwise the node arbitrates
// on every beat and the FSM never leaves IDLE.
//
// state  | meaning
// IDLE   | round-robin over all children
// LOCKED | mid-packet, only lock_ch may be granted
module hier_node_mux
  import hier_node_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int ID_W   = id_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [ID_W-1:0]          out_id
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   lock_ch;
  logic [ID_W-1:0]   lock_nxt;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [ID_W-1:0]   g_idx;
  logic [ID_W-1:0]   g_after;
  logic              take;
  logic              accept;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  // Slot can load when empty or being drained this cycle.
  assign take = !out_valid || out_ready;

  // Eligible requests: everyone in IDLE, only the locked child in LOCKED.
  always_comb begin
    req = in_valid;
`ifdef HIER_NODE_PKT_LOCK_EN
    if (state == LOCKED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        req[i] = in_valid[i] && (lock_ch == ID_W'(i));
      end
    end
`endif
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .en        (take && rst_n),
    .grant     (grant),
    .grant_idx (g_idx)
  );

  assign in_ready = grant;
  assign accept   = |grant;
  assign g_after  = (g_idx == ID_W'(NUM_CH - 1)) ? '0 : g_idx + ID_W'(1);

  // Payload mux for the granted child; only ever feeds the slot registers.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g_idx == ID_W'(i)) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
        sel_last = in_last[i];
      end
    end
  end

  // Lock FSM next state and round-robin pointer update.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock_ch;
`ifdef HIER_NODE_PKT_LOCK_EN
    if (accept) begin
      case (state)
        IDLE: begin
          if (sel_last) begin
            ptr_nxt = g_after;
          end else begin
            state_nxt = LOCKED;
            lock_nxt  = g_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_nxt = IDLE;
            ptr_nxt   = g_after;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
`else
    if (accept) ptr_nxt = g_after;
`endif
  end

  // State, pointer and lock owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      lock_ch <= lock_nxt;
    end
  end

  // Output slot: load on accept, empty on a drain without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_id    <= g_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hier_node_mux.sv
// Directed bench for hier_node_mux (NUM_CH=5, DATA_W=32). Covers both builds
// of the HIER_NODE_PKT_LOCK_EN option.
module tb_hier_node_mux;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 32;
  localparam int ID_W   = 3;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [ID_W-1:0]          out_id;

  int errors = 0;
  int checks = 0;

  hier_node_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] d, input logic l);
    in_data[i*DATA_W +: DATA_W] = d;
    in_last[i] = l;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] id, input logic [31:0] d,
                          input logic [31:0] l);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_id"},    32'(out_id),    id);
    chk({tag, "_data"},  out_data,       d);
    chk({tag, "_last"},  32'(out_last),  l);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 5'h1F;
    in_last   = 5'h1F;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'h1000 + 32'(i), 1'b1);

    // reset with all children valid
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_out_id",    32'(out_id),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h01);

    // all valid, back-to-back round robin 0,1,2,3,4,0
    tick(); chk_beat("rr0", 32'h0, 32'h1000, 32'h1);
    tick(); chk_beat("rr1", 32'h1, 32'h1001, 32'h1);
    tick(); chk_beat("rr2", 32'h2, 32'h1002, 32'h1);
    tick(); chk_beat("rr3", 32'h3, 32'h1003, 32'h1);
    tick(); chk_beat("rr4", 32'h4, 32'h1004, 32'h1);
    tick(); chk_beat("rr5", 32'h0, 32'h1000, 32'h1);

    // sparse requests: ch3 alone moves ptr to 4, then 1,3,1,3 with wrap
    in_valid = 5'b01000;
    #1;
    chk("sp_in_ready3", 32'(in_ready), 32'h08);
    tick(); chk_beat("sp_a", 32'h3, 32'h1003, 32'h1);
    in_valid = 5'b01010;
    #1;
    chk("sp_in_ready_wrap", 32'(in_ready), 32'h02);
    tick(); chk_beat("sp_b", 32'h1, 32'h1001, 32'h1);
    tick(); chk_beat("sp_c", 32'h3, 32'h1003, 32'h1);
    tick(); chk_beat("sp_d", 32'h1, 32'h1001, 32'h1);
    tick(); chk_beat("sp_e", 32'h3, 32'h1003, 32'h1);

    // stall with full slot for 4 cycles, ptr=4
    out_ready = 1'b0;
    in_valid  = 5'h1F;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_beat("stall", 32'h3, 32'h1003, 32'h1);
      chk("stall_in_ready_c", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'h10);
    tick(); chk_beat("unstall", 32'h4, 32'h1004, 32'h1);

    // drain with no requests; ptr wrapped to 0 and holds
    in_valid = 5'h00;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h0);
    tick(); chk("drain_valid", 32'(out_valid), 32'h0);
    tick(); chk("empty_valid", 32'(out_valid), 32'h0);
    in_valid = 5'h1F;
    #1;
    chk("ptr_hold_in_ready", 32'(in_ready), 32'h01);
    in_valid = 5'b00010;
    tick(); chk_beat("pre_pkt", 32'h1, 32'h1001, 32'h1);

    // ch2 sends a 3-beat packet while ch0 stays valid, ptr=2
    set_ch(2, 32'h2001, 1'b0);
    in_valid = 5'b00101;
`ifdef HIER_NODE_PKT_LOCK_EN
    tick(); chk_beat("pkt1", 32'h2, 32'h2001, 32'h0);
    set_ch(2, 32'h2002, 1'b0);
    #1;
    chk("lock_in_ready", 32'(in_ready), 32'h04);
    tick(); chk_beat("pkt2", 32'h2, 32'h2002, 32'h0);
    set_ch(2, 32'h2003, 1'b1);
    tick(); chk_beat("pkt3", 32'h2, 32'h2003, 32'h1);
    in_valid = 5'b00001;
    tick(); chk_beat("pkt4", 32'h0, 32'h1000, 32'h1);
`else
    tick(); chk_beat("pkt1", 32'h2, 32'h2001, 32'h0);
    set_ch(2, 32'h2002, 1'b0);
    #1;
    chk("nolock_in_ready", 32'(in_ready), 32'h01);
    tick(); chk_beat("pkt2", 32'h0, 32'h1000, 32'h1);
    tick(); chk_beat("pkt3", 32'h2, 32'h2002, 32'h0);
    set_ch(2, 32'h2003, 1'b1);
    tick(); chk_beat("pkt4", 32'h0, 32'h1000, 32'h1);
    tick(); chk_beat("pkt5", 32'h2, 32'h2003, 32'h1);
`endif

    // reset mid-packet (LOCKED when the lock build is used)
    set_ch(2, 32'h2010, 1'b0);
    in_valid = 5'b00100;
    tick(); chk_beat("mid_pkt", 32'h2, 32'h2010, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid), 32'h0);
    chk("mid_rst_data",     out_data,       32'h0);
    chk("mid_rst_id",       32'(out_id),    32'h0);
    chk("mid_rst_last",     32'(out_last),  32'h0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'h0);
    #2;
    rst_n = 1'b1;
    set_ch(2, 32'h1002, 1'b1);
    in_valid = 5'h1F;
    #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'h01);
    tick(); chk_beat("after_rst0", 32'h0, 32'h1000, 32'h1);
    tick(); chk_beat("after_rst1", 32'h1, 32'h1001, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
